reorder_buffer: RTL and testbench

- Circular reorder buffer that owns the 6-bit rename tags consumed by the architected register file.
- At dispatch it hands out the next free entry as `rob_free_entry`.
- It captures results broadcast on the common data bus by tag.
- It retires entries strictly in order, driving the architected register file write port (`arf_write_enable` / `arf_write_reg` / `arf_write_data`).
- It also serves operand lookups for source tags still marked busy in the register file.

---
 rtl/reorder_buffer.sv | 100 ++++++++++
 tb/tb_reorder_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular 64-entry reorder buffer: allocates rename tags at dispatch, captures CDB results
// by tag, retires in order to the architected register file. Optional macro ROB_CDB_BYPASS_EN.
module reorder_buffer #(
   parameter int TAG_W = 6,
   parameter int DEPTH = 2**TAG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dp_valid,
   input  logic [4:0]       dp_dest,
   output logic [TAG_W-1:0] rob_free_entry,
   output logic             rob_full,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_data,
   input  logic [TAG_W-1:0] rob_read_tag1,
   input  logic [TAG_W-1:0] rob_read_tag2,
   output logic             rob_ready1,
   output logic             rob_ready2,
   output logic [31:0]      rob_data1,
   output logic [31:0]      rob_data2,
   input  logic             flush,
   output logic             arf_write_enable,
   output logic [4:0]       arf_write_reg,
   output logic [31:0]      arf_write_data
);

   localparam logic [TAG_W:0] FULL_CNT = DEPTH[TAG_W:0];

   logic             r_valid [DEPTH];
   logic             r_ready [DEPTH];
   logic [4:0]       r_dest  [DEPTH];
   logic [31:0]      r_data  [DEPTH];
   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [TAG_W:0]   r_count;

   logic w_dp_accept;
   logic w_retire;
   logic w_commit;

   assign rob_full       = (r_count == FULL_CNT);
   assign rob_free_entry = r_tail;
   assign w_dp_accept    = dp_valid && !rob_full;
   assign w_retire       = r_valid[r_head] && r_ready[r_head];
   // flush/reset squash the commit, so nothing reaches the ARF on that edge
   assign w_commit       = w_retire && !flush && !reset;

   assign arf_write_enable = w_commit && (r_dest[r_head] != 5'd0);
   assign arf_write_reg    = w_commit ? r_dest[r_head] : 5'd0;
   assign arf_write_data   = w_commit ? r_data[r_head] : 32'd0;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (cdb_valid && r_valid[cdb_tag]) begin
            r_ready[cdb_tag] <= 1'b1;
            r_data[cdb_tag]  <= cdb_data;
         end
         if (w_dp_accept) begin
            r_valid[r_tail] <= 1'b1;
            r_ready[r_tail] <= 1'b0;
            r_dest[r_tail]  <= dp_dest;
            r_data[r_tail]  <= 32'd0;
            r_tail          <= r_tail + 1'b1;
         end
         if (w_retire) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         case ({w_dp_accept, w_retire})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      rob_ready1 = r_valid[rob_read_tag1] && r_ready[rob_read_tag1];
      rob_data1  = rob_ready1 ? r_data[rob_read_tag1] : 32'd0;
      rob_ready2 = r_valid[rob_read_tag2] && r_ready[rob_read_tag2];
      rob_data2  = rob_ready2 ? r_data[rob_read_tag2] : 32'd0;
`ifdef ROB_CDB_BYPASS_EN
      if (cdb_valid && r_valid[cdb_tag] && (cdb_tag == rob_read_tag1)) begin
         rob_ready1 = 1'b1;
         rob_data1  = cdb_data;
      end
      if (cdb_valid && r_valid[cdb_tag] && (cdb_tag == rob_read_tag2)) begin
         rob_ready2 = 1'b1;
         rob_data2  = cdb_data;
      end
`endif
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a
// program-order queue model of the in-flight instructions.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        dp_valid = 1'b0;
   logic [4:0]  dp_dest = '0;
   logic [5:0]  rob_free_entry;
   logic        rob_full;
   logic        cdb_valid = 1'b0;
   logic [5:0]  cdb_tag = '0;
   logic [31:0] cdb_data = '0;
   logic [5:0]  rob_read_tag1 = '0;
   logic [5:0]  rob_read_tag2 = '0;
   logic        rob_ready1, rob_ready2;
   logic [31:0] rob_data1, rob_data2;
   logic        flush = 1'b0;
   logic        arf_write_enable;
   logic [4:0]  arf_write_reg;
   logic [31:0] arf_write_data;

   int checks = 0;
   int failures = 0;

   reorder_buffer dut (
      .clk(clk), .reset(reset), .dp_valid(dp_valid), .dp_dest(dp_dest),
      .rob_free_entry(rob_free_entry), .rob_full(rob_full),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rob_read_tag1(rob_read_tag1), .rob_read_tag2(rob_read_tag2),
      .rob_ready1(rob_ready1), .rob_ready2(rob_ready2),
      .rob_data1(rob_data1), .rob_data2(rob_data2),
      .flush(flush), .arf_write_enable(arf_write_enable),
      .arf_write_reg(arf_write_reg), .arf_write_data(arf_write_data)
   );

   always #5 clk = ~clk;

   // in-flight instructions in program order; front is the oldest
   typedef struct {
      int          tag;
      int          dest;
      bit          rdy;
      logic [31:0] data;
   } ent_t;
   ent_t q[$];
   int   next_tag = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void lookup(input int t, output bit r, output logic [31:0] d);
      bit found = 0;
      r = 0;
      d = 0;
      foreach (q[i]) if (q[i].tag == t) begin
         found = 1;
         r = q[i].rdy;
         d = q[i].rdy ? q[i].data : 32'd0;
      end
`ifdef ROB_CDB_BYPASS_EN
      if (found && cdb_valid && int'(cdb_tag) == t) begin
         r = 1;
         d = cdb_data;
      end
`endif
   endfunction

   task automatic compare_all();
      bit          ret, r;
      logic [31:0] d;
      ret = (q.size() > 0) && q[0].rdy && !reset && !flush;
      chk("full", rob_full, q.size() == 64);
      chk("free_entry", rob_free_entry, next_tag);
      chk("arf_we", arf_write_enable, ret && q[0].dest != 0);
      chk("arf_reg", arf_write_reg, ret ? q[0].dest : 0);
      chk("arf_data", arf_write_data, ret ? q[0].data : 32'd0);
      lookup(rob_read_tag1, r, d);
      chk("ready1", rob_ready1, r);
      chk("data1", rob_data1, d);
      lookup(rob_read_tag2, r, d);
      chk("ready2", rob_ready2, r);
      chk("data2", rob_data2, d);
   endtask

   task automatic model_edge();
      bit ret, acc;
      if (reset || flush) begin
         q.delete();
         next_tag = 0;
      end else begin
         ret = (q.size() > 0) && q[0].rdy;
         acc = dp_valid && (q.size() < 64);
         if (cdb_valid) foreach (q[i]) if (q[i].tag == int'(cdb_tag)) begin
            q[i].rdy  = 1;
            q[i].data = cdb_data;
         end
         if (ret) void'(q.pop_front());
         if (acc) begin
            q.push_back('{tag: next_tag, dest: int'(dp_dest), rdy: 1'b0, data: 32'd0});
            next_tag = (next_tag + 1) % 64;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit dv, input int dd, input bit cv, input int ct,
                        input logic [31:0] cd, input bit fl, input bit rs);
      dp_valid  = dv;
      dp_dest   = 5'(dd);
      cdb_valid = cv;
      cdb_tag   = 6'(ct);
      cdb_data  = cd;
      flush     = fl;
      reset     = rs;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 1);
      cycle();
      cycle();
      idle();
   endtask

   initial begin
      rob_read_tag1 = 0;
      rob_read_tag2 = 1;
      do_reset();
      chk("rst_full", rob_full, 0);
      chk("rst_free", rob_free_entry, 0);
      chk("rst_we", arf_write_enable, 0);

      // single dispatch -> writeback -> commit
      drive(1, 5, 0, 0, 0, 0, 0);
      chk("t1_free_before", rob_free_entry, 0);
      cycle();
      idle();
      chk("t1_free_after", rob_free_entry, 1);
      cycle();
      drive(0, 0, 1, 0, 32'h1234, 0, 0);
      chk("t1_no_commit_same_edge", arf_write_enable, 0);
      cycle();
      idle();
      chk("t1_we", arf_write_enable, 1);
      chk("t1_reg", arf_write_reg, 5);
      chk("t1_data", arf_write_data, 32'h1234);
      cycle();
      chk("t1_we_after", arf_write_enable, 0);
      cycle();

      // out-of-order writeback, in-order commit
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, i + 1, 0, 0, 0, 0, 0);
         cycle();
      end
      drive(0, 0, 1, 2, 32'hC, 0, 0); chk("ooo_we_c", arf_write_enable, 0); cycle();
      drive(0, 0, 1, 1, 32'hB, 0, 0); chk("ooo_we_b", arf_write_enable, 0); cycle();
      drive(0, 0, 1, 0, 32'hA, 0, 0); chk("ooo_we_a", arf_write_enable, 0); cycle();
      idle();
      for (int i = 0; i < 3; i++) begin
         chk("ooo_we", arf_write_enable, 1);
         chk("ooo_reg", arf_write_reg, i + 1);
         chk("ooo_data", arf_write_data, 32'hA + i);
         cycle();
      end
      chk("ooo_done", arf_write_enable, 0);
      cycle();

      // fill, reject, retire while full, wrap-around
      do_reset();
      for (int i = 0; i < 64; i++) begin
         drive(1, (i % 31) + 1, 0, 0, 0, 0, 0);
         cycle();
      end
      chk("fill_full", rob_full, 1);
      chk("fill_free", rob_free_entry, 0);
      cycle();
      chk("fill_65th_free", rob_free_entry, 0);
      drive(1, 9, 1, 0, 32'hBEEF, 0, 0);
      cycle();
      drive(1, 9, 0, 0, 0, 0, 0);
      chk("fill_full_retire", rob_full, 1);
      chk("fill_retire_we", arf_write_enable, 1);
      cycle();
      idle();
      chk("fill_not_full", rob_full, 0);
      chk("fill_wrap_free", rob_free_entry, 0);
      drive(1, 7, 0, 0, 0, 0, 0);
      cycle();
      idle();
      chk("fill_wrap_tail", rob_free_entry, 1);
      chk("fill_full_again", rob_full, 1);
      cycle();

      // dest x0 retires silently
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 0); cycle();
      drive(0, 0, 1, 0, 32'h77, 0, 0); cycle();
      idle();
      chk("x0_we", arf_write_enable, 0);
      cycle();
      rob_read_tag1 = 0;
      #1;
      chk("x0_retired", rob_ready1, 0);
      cycle();

      // lookup, with and without same-cycle bypass
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 10 + i, 0, 0, 0, 0, 0);
         cycle();
      end
      rob_read_tag1 = 3;
      idle();
      chk("lk_not_ready", rob_ready1, 0);
      chk("lk_data0", rob_data1, 0);
      drive(0, 0, 1, 3, 32'h55, 0, 0);
`ifdef ROB_CDB_BYPASS_EN
      chk("lk_bypass_rdy", rob_ready1, 1);
      chk("lk_bypass_data", rob_data1, 32'h55);
`else
      chk("lk_nobypass_rdy", rob_ready1, 0);
      chk("lk_nobypass_data", rob_data1, 0);
`endif
      cycle();
      idle();
      chk("lk_rdy_next", rob_ready1, 1);
      chk("lk_data_next", rob_data1, 32'h55);
      cycle();

      // flush with live entries, concurrent dispatch and ready head
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, 20 + i, 0, 0, 0, 0, 0);
         cycle();
      end
      drive(0, 0, 1, 0, 32'h99, 0, 0); cycle();
      drive(0, 0, 1, 5, 32'h98, 0, 0); cycle();
      rob_read_tag1 = 5;
      rob_read_tag2 = 6;
      drive(1, 3, 0, 0, 0, 1, 0);
      chk("fl_we", arf_write_enable, 0);
      cycle();
      idle();
      chk("fl_free", rob_free_entry, 0);
      chk("fl_full", rob_full, 0);
      chk("fl_rdy1", rob_ready1, 0);
      chk("fl_rdy2", rob_ready2, 0);
      cycle();

      // random traffic: heavy dispatch phase then heavy writeback phase
      for (int n = 0; n < 5000; n++) begin
         int  pd   = (n < 2500) ? 75 : 40;
         int  pc   = (n < 2500) ? 30 : 85;
         int  ct;
         bit  fl   = ($urandom_range(399, 0) == 0);
         bit  rs   = ($urandom_range(799, 0) == 0);
         if (q.size() > 0 && $urandom_range(3, 0) != 0)
            ct = q[$urandom_range(q.size() - 1, 0)].tag;
         else
            ct = $urandom_range(63, 0);
         rob_read_tag1 = (q.size() > 0 && $urandom_range(1, 0) == 1) ? 6'(ct) : 6'($urandom_range(63, 0));
         rob_read_tag2 = (q.size() > 0) ? 6'(q[$urandom_range(q.size() - 1, 0)].tag) : 6'($urandom_range(63, 0));
         drive($urandom_range(99, 0) < pd, $urandom_range(31, 0),
               $urandom_range(99, 0) < pc, ct, $urandom, fl, rs);
         cycle();
      end
      idle();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
